// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M/RV64M multiply/divide execute unit.
// Multiplies finish after MUL_STAGES cycles; divides run XLEN/DIV_BITS
// restoring iterations on operand magnitudes, with the sign fix-up applied
// as the final iteration's result is written.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, a divide
// whose dividend magnitude is below the divisor magnitude skips iteration.
// Handshake: a transfer happens on a rising edge where valid && ready;
// req_ready is high only in IDLE, resp_valid only in DONE, and resp_data /
// resp_rd are held stable until the DONE handshake (or a flush) completes.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            busy,
  output logic [1:0]      dbg_state
);
  localparam int N  = XLEN / DIV_BITS;
  localparam int CW = $clog2(N + MUL_STAGES + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
  state_t state, state_n;

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, rem_q;
  logic            q_neg, r_neg;
  logic [CW-1:0]   cnt;

  logic            accept, is_div, div_signed, a_neg, b_neg, b_zero, ovf, early, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic [XLEN-1:0] quo_n, rem_n, div_res;
  logic [XLEN:0]   trial;

  // Full 2*XLEN product with operand signedness selected by funct3.
  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ax, bx, p;
    ax = {{XLEN{((op == 3'd1) || (op == 3'd2)) && a[XLEN-1]}}, a};
    bx = {{XLEN{(op == 3'd1) && b[XLEN-1]}}, b};
    p  = ax * bx;
    return (op[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // Request decode: operand magnitudes and the divide special cases.
  always_comb begin
    accept     = req_valid && req_ready && !flush;
    is_div     = req_op[2];
    div_signed = is_div && !req_op[0];
    a_neg      = div_signed && req_a[XLEN-1];
    b_neg      = div_signed && req_b[XLEN-1];
    mag_a      = a_neg ? -req_a : req_a;
    mag_b      = b_neg ? -req_b : req_b;
    b_zero     = (req_b == '0);
    ovf        = div_signed && (req_a == MIN_NEG) && (req_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early      = is_div && !b_zero && !ovf && (mag_a < mag_b);
`else
    early      = 1'b0;
`endif
    special    = is_div && (b_zero || ovf || early);
    // req_op[1] selects the remainder variants (REM/REMU)
    if (b_zero)   special_res = req_op[1] ? req_a : '1;
    else if (ovf) special_res = req_op[1] ? '0 : req_a;
    else          special_res = req_op[1] ? req_a : '0;
  end

  // Restoring divide step: DIV_BITS quotient bits per cycle, then sign fix-up.
  always_comb begin
    rem_n = rem_q;
    quo_n = a_q;
    trial = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {rem_n, quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, b_q}) begin
        trial    = trial - {1'b0, b_q};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[XLEN-1:0];
    end
    if (op_q[1]) div_res = r_neg ? -rem_n : rem_n;
    else         div_res = q_neg ? -quo_n : quo_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; flush overrides everything, including a DONE handshake.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) begin
        if (special)              state_n = S_DONE;
        else if (is_div)          state_n = S_DIV;
        else if (MUL_STAGES == 1) state_n = S_DONE;
        else                      state_n = S_MUL;
      end
      S_MUL:  if (cnt == '0) state_n = S_DONE;
      S_DIV:  if (cnt == '0) state_n = S_DONE;
      S_DONE: if (resp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  // Operand capture, iteration datapath, counter and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q    <= req_op;
          resp_rd <= req_rd;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          rem_q   <= '0;
          if (is_div) begin
            a_q <= mag_a;
            b_q <= mag_b;
            cnt <= CW'(N - 1);
          end else begin
            a_q <= req_a;
            b_q <= req_b;
            cnt <= CW'((MUL_STAGES >= 2) ? (MUL_STAGES - 2) : 0);
          end
          if (special)                            resp_data <= special_res;
          else if (!is_div && (MUL_STAGES == 1)) resp_data <= mul_result(req_op, req_a, req_b);
        end
        S_MUL: begin
          if (cnt == '0) resp_data <= mul_result(op_q, a_q, b_q);
          else           cnt <= cnt - CW'(1);
        end
        S_DIV: begin
          a_q   <= quo_n;
          rem_q <= rem_n;
          if (cnt == '0) resp_data <= div_res;
          else           cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
